// File: rtl/maze_pkg.sv
// maze_pkg: direction encoding, stack sizing and FSM states shared by the maze solver blocks.
package maze_pkg;

    localparam int MAX_DEPTH = 256;
    localparam int DIR_W = 2;
    localparam int CW = $clog2(MAX_DEPTH + 1);

    localparam logic [DIR_W-1:0] DIR_YM = 2'b00;
    localparam logic [DIR_W-1:0] DIR_XP = 2'b01;
    localparam logic [DIR_W-1:0] DIR_XM = 2'b10;
    localparam logic [DIR_W-1:0] DIR_YP = 2'b11;

    typedef enum logic [1:0] {IDLE, REPLAY, DONE} state_t;

    // Opposite moves are bitwise complements in this encoding.
    function automatic logic [DIR_W-1:0] revDir(input logic [DIR_W-1:0] d);
        return ~d;
    endfunction

endpackage

// File: rtl/path_stack_if.sv
// path_stack_if: push/pop, status and replay signals of the path stack.
interface path_stack_if import maze_pkg::*; #(
    parameter int DEPTH = MAX_DEPTH,
    parameter int DW = DIR_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clr;
    logic             push;
    logic             pop;
    logic [DW-1:0]    dirIn;
    logic [DW-1:0]    topDir;
    logic [DW-1:0]    backDir;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             err;
    logic             replayStart;
    logic             replayNext;
    logic [DW-1:0]    dirOut;
    logic             replayValid;
    logic             replayDone;

    modport master (
        output clr, push, pop, dirIn, replayStart, replayNext,
        input  topDir, backDir, count, empty, full, err, dirOut, replayValid, replayDone
    );

    modport slave (
        input  clr, push, pop, dirIn, replayStart, replayNext,
        output topDir, backDir, count, empty, full, err, dirOut, replayValid, replayDone
    );
endinterface

// File: rtl/stackMem.sv
// stackMem: register file with one synchronous write port and two combinational read ports.
module stackMem #(
    parameter int DEPTH = 256,
    parameter int DW = 2,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] top_addr,
    output logic [DW-1:0] top_data,
    input  logic [AW-1:0] rep_addr,
    output logic [DW-1:0] rep_data
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign top_data = mem[top_addr];
    assign rep_data = mem[rep_addr];
endmodule

// File: rtl/path_stack.sv
// path_stack: LIFO of committed maze moves with backtrack readout and bottom-to-top replay.
module path_stack import maze_pkg::*; #(
    parameter int DEPTH = MAX_DEPTH,
    parameter int DW = DIR_W
) (
    input logic            clk,
    input logic            rst,
    path_stack_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [AW-1:0]    rp, rp_nx;
    logic             err, err_nx;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_idx;
    logic [DW-1:0]    top_data, rep_data;
    logic             empty, full;

    assign empty = count == '0;
    assign full = count == CNT_W'(DEPTH);
    assign top_idx = AW'(count - 1'b1);

    stackMem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_mem (
        .clk(clk),
        .we(we),
        .waddr(waddr),
        .wdata(bus.dirIn),
        .top_addr(top_idx),
        .top_data(top_data),
        .rep_addr(rp),
        .rep_data(rep_data)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            count <= '0;
            rp <= '0;
            err <= 1'b0;
        end else if (bus.clr) begin
            state <= IDLE;
            count <= '0;
            rp <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            rp <= rp_nx;
            err <= err_nx;
        end

    // replayStart outranks push/pop; a simultaneous push&pop on a non-empty stack rewrites the top.
    always_comb begin
        state_nx = state;
        count_nx = count;
        rp_nx = rp;
        err_nx = err;
        we = 1'b0;
        waddr = count[AW-1:0];
        case (state)
            IDLE:
                if (bus.replayStart) begin
                    state_nx = empty ? DONE : REPLAY;
                    rp_nx = '0;
                end else if (bus.push && bus.pop && !empty) begin
                    we = !bus.clr;
                    waddr = top_idx;
                end else if (bus.push) begin
                    err_nx = err | full;
                    we = !full && !bus.clr;
                    count_nx = full ? count : count + 1'b1;
                end else if (bus.pop) begin
                    err_nx = err | empty;
                    count_nx = empty ? count : count - 1'b1;
                end
            REPLAY:
                if (bus.replayNext) begin
                    state_nx = rp == top_idx ? DONE : REPLAY;
                    rp_nx = rp == top_idx ? rp : rp + 1'b1;
                end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.count = count;
    assign bus.empty = empty;
    assign bus.full = full;
    assign bus.err = err;
    assign bus.topDir = empty ? '0 : top_data;
    assign bus.backDir = empty ? '0 : revDir(top_data);
    assign bus.replayValid = state == REPLAY;
    assign bus.dirOut = state == REPLAY ? rep_data : '0;
    assign bus.replayDone = state == DONE;
endmodule
